spi_bus_arbiter: RTL
====================

// Module: spi_bus_arbiter
// PURPOSE
//  Shares one Pmod SPI bus (SCLK/MOSI/MISO) between NREQ peripheral engines (ALS, ACL2, ...).
//  Uses a req/grant handshake with round-robin fairness and a mandatory idle guard between owners.
//  Drives one active-low chip select per device; a watchdog revokes an owner that holds the bus too long.
//  Sits between the peripheral engines and the board pins at top level.
// PARAMETERS
//  NREQ      2     number of requesters/devices (2..8)
//  GUARD     4     idle cycles (all CS high, SCLK idle) inserted after every release/revoke
//  MAX_HOLD  0     watchdog limit in cycles of continuous ownership; 0 = watchdog disabled
//  CPOL      0     idle level driven on SCLK when no owner
// PORTS
//  Clock     in   1     system clock
//  Reset     in   1     synchronous, active-low reset
//  req       in   NREQ  bus request per engine; held high for whole transaction
//  grant     out  NREQ  one-hot (or zero) ownership indication, registered
//  req_sclk  in   NREQ  SCLK from each engine
//  req_mosi  in   NREQ  MOSI from each engine
//  req_cs    in   NREQ  active-low CS from each engine for its own device
//  req_miso  out  1     MISO broadcast to all engines (wire-through, unregistered)
//  MISO      in   1     bus MISO pin
//  SCLK      out  1     bus clock pin, registered
//  MOSI      out  1     bus data pin, registered
//  CS        out  NREQ  device chip selects, active-low, registered
//  busy      out  1     high in OWNED or GUARD
//  timeout   out  1     one-cycle pulse when watchdog revokes a grant
// BEHAVIOUR
//  Reset (Reset==0 at posedge): state IDLE, grant=0, CS=all 1, SCLK=CPOL, MOSI=0, busy=0,
//   timeout=0, rr pointer=0, hold counter=0. Reset mid-transaction drops everything same edge.
//  States: IDLE, OWNED, GUARD.
//  IDLE: if any req, pick first set bit searching from rr pointer upward (wrap at NREQ-1->0);
//   owner<=pick, grant[pick]<=1, state<=OWNED, pointer<=pick+1 mod NREQ. req at edge t -> grant high after t+1.
//  OWNED: SCLK<=req_sclk[owner], MOSI<=req_mosi[owner], CS[owner]<=req_cs[owner], other CS<=1
//   (one-cycle pin latency). hold counter increments each cycle, saturating.
//   req[owner]==0 -> grant<=0, CS<=all 1, SCLK<=CPOL, MOSI<=0, state<=GUARD.
//   MAX_HOLD!=0 and hold count==MAX_HOLD-1 while req[owner] still high -> same as release plus
//   timeout<=1 for one cycle; that engine must drop req before it can be re-granted (no re-grant
//   while its req has not been seen low since revoke).
//  GUARD: pins idle; count GUARD cycles then IDLE. Requests arriving in GUARD wait (no grant early).
//   GUARD=0 -> go directly OWNED->IDLE next cycle.
//  Simultaneous requests: only pointer order decides; a requester whose req drops before grant
//   is simply not selected. Owner's req drop and watchdog hit same cycle -> treated as release, no timeout.
//  grant is never asserted for more than one requester; CS never low for more than one device.
//  req_sclk/mosi/cs of non-owners are ignored.
// STRUCTURE
//  Shared package alarm_spi_pkg: arb_state_t enum {IDLE,OWNED,GUARD}, CS_IDLE=1'b1,
//   idx width function clog2(NREQ).
//  One sub-module: rr_pick (combinational round-robin picker: req, pointer -> valid, index).
//  Everything else (FSM, counters, registered pin mux) in this module.
// TESTING
//  1 Reset held low 3 cycles with req=2'b11 -> grant=0, CS=2'b11, SCLK=CPOL, busy=0 throughout.
//  2 req=2'b01 from idle -> grant=2'b01 one cycle later; engine toggles req_sclk 8 times -> SCLK
//    mirrors it delayed 1 cycle, CS=2'b10; req drops -> CS=2'b11, 4 idle cycles, then IDLE.
//  3 req=2'b11 constant, each engine releases after 10 cycles -> grants alternate 01,10,01,...;
//    never overlapping, GUARD gap of 4 cycles between them.
//  4 MAX_HOLD=16, req[1] stuck high -> grant[1] drops after 16 cycles, timeout pulse 1 cycle,
//    req[0] granted after guard; req[1] not re-granted until it toggles low then high.
//  5 Reset asserted while OWNED with CS low -> next edge CS=all 1, grant=0, state IDLE, pointer=0.
//  6 NREQ=3, pointer at 2, req=3'b011 -> index 0 granted (wrap), pointer becomes 1.

Source files
------------

// File: rtl/spi_bus_arbiter_pkg.sv
// Shared types and helpers for the Pmod SPI bus arbiter.
package alarm_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        GUARD = 2'd2
    } arb_state_t;

    localparam logic CS_IDLE = 1'b1;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Engine-side request/grant and per-engine SPI signals of the bus arbiter.
interface spi_bus_arbiter_if #(
    parameter int unsigned NREQ = 2
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] req_sclk;
    logic [NREQ-1:0] req_mosi;
    logic [NREQ-1:0] req_cs;
    logic            req_miso;

    modport master (
        output req, req_sclk, req_mosi, req_cs,
        input  grant, req_miso
    );

    modport slave (
        input  req, req_sclk, req_mosi, req_cs,
        output grant, req_miso
    );
endinterface

// File: rtl/spi_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module rr_pick
    import alarm_spi_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [NREQ-1:0]  rot;
    logic [SUM_W-1:0] sum;

    // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
    always_comb begin
        rot   = NREQ'({req, req} >> ptr);
        valid = |rot;
        sum   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = SUM_W'(ptr) + SUM_W'(k);
            end
        end
        if (sum >= SUM_W'(NREQ)) begin
            sum = sum - SUM_W'(NREQ);
        end
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI bus between NREQ engines: round-robin grant, idle guard, hold watchdog.
module spi_bus_arbiter #(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned GUARD    = 4,
    parameter int unsigned MAX_HOLD = 0,
    parameter bit          CPOL     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_bus_arbiter_if.slave bus,
    input  logic             MISO,
    output logic             SCLK,
    output logic             MOSI,
    output logic [NREQ-1:0]  CS,
    output logic             busy,
    output logic             timeout
);

    import alarm_spi_pkg::*;

    localparam int unsigned IDX_W  = clog2(NREQ);
    localparam int unsigned GRD_W  = clog2(GUARD + 1);
    localparam int unsigned HOLD_W = clog2(MAX_HOLD + 1);

    localparam logic [GRD_W-1:0]  GUARD_LAST = (GUARD == 0)    ? '0 : GRD_W'(GUARD - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GRD_W-1:0]  guard_q, guard_d;
    logic [NREQ-1:0]   locked_q, locked_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   cs_q, cs_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic              release_c;
    logic              wd_hit_c;

    // Revoked engines stay masked until their request has been seen low.
    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (bus.req & ~locked_q),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign release_c = ~bus.req[owner_q];
    assign wd_hit_c  = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            guard_q   <= '0;
            locked_q  <= '0;
            grant_q   <= '0;
            cs_q      <= {NREQ{CS_IDLE}};
            sclk_q    <= CPOL;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            guard_q   <= guard_d;
            locked_q  <= locked_d;
            grant_q   <= grant_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state plus next pin values; pins default to idle every cycle.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        guard_d   = guard_q;
        locked_d  = locked_q & bus.req;
        grant_d   = grant_q;
        cs_d      = {NREQ{CS_IDLE}};
        sclk_d    = CPOL;
        mosi_d    = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_valid) begin
                    owner_d = pick_idx;
                    grant_d = NREQ'(1) << pick_idx;
                    hold_d  = '0;
                    state_d = OWNED;
                    ptr_d   = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                end
            end
            OWNED: begin
                if (release_c || wd_hit_c) begin
                    grant_d = '0;
                    guard_d = '0;
                    if (GUARD == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = alarm_spi_pkg::GUARD;
                    end
                    // A simultaneous release wins over the watchdog.
                    if (!release_c) begin
                        timeout_d         = 1'b1;
                        locked_d[owner_q] = 1'b1;
                    end
                end else begin
                    sclk_d        = bus.req_sclk[owner_q];
                    mosi_d        = bus.req_mosi[owner_q];
                    cs_d[owner_q] = bus.req_cs[owner_q];
                    if (hold_q != '1) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            alarm_spi_pkg::GUARD: begin
                grant_d = '0;
                if (guard_q == GUARD_LAST) begin
                    state_d = IDLE;
                end else begin
                    guard_d = guard_q + GRD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.grant    = grant_q;
    assign bus.req_miso = MISO;
    assign SCLK         = sclk_q;
    assign MOSI         = mosi_q;
    assign CS           = cs_q;
    assign busy         = busy_q;
    assign timeout      = timeout_q;

endmodule
